uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with the following ports:
  - clk  in  1  receive oversampling clock; all state on rising edge.
  - rst  in  1  asynchronous active-low reset.
  - rx_in  in  1  serial line, already synchronous to clk; idle high.
  - prescale  in  6  oversampling ratio; legal values 8, 16, 32.
  - enable  in  1  frame-in-progress, from the RX FSM; enables the counters.
  - dat_samp_en  in  1  sampling enable, from the RX FSM.
  - edge_cnt  out  6  oversample position within the current bit.
  - bit_cnt  out  4  bit index within the frame.
  - sampled_bit  out  1  majority-voted bit value, consumed by the parity, start and stop checkers.
  - sample_valid  out  1  one-cycle pulse: sampled_bit newly updated.

Function
REQ-003 Prescale SHALL be captured into an internal register P on every clock while enable=0 and held constant while enable=1.
REQ-004 Values of prescale other than 8, 16 or 32 SHALL be treated as 8 when captured.
REQ-005 While enable=1, edge_cnt SHALL increment by 1 per clock, from 0 to P-1.
REQ-006 When edge_cnt=P-1 with enable=1, the next clock SHALL set edge_cnt=0 and bit_cnt=bit_cnt+1.
REQ-007 bit_cnt SHALL wrap from 15 to 0 (modulo 16).
REQ-008 While enable=0, edge_cnt and bit_cnt SHALL be cleared to 0 on the next clock.
REQ-009 Let H=P/2. While dat_samp_en=1, rx_in SHALL be registered into s0 on the clock where edge_cnt=H-2, and into s1 on the clock where edge_cnt=H-1.
REQ-010 On the clock where edge_cnt=H and dat_samp_en=1, sampled_bit SHALL be loaded with majority(s0, s1, rx_in), i.e. true when at least 2 of the 3 are 1.
REQ-011 sample_valid SHALL be 1 for exactly the one cycle following the clock of REQ-010 (edge_cnt=H+1), and 0 otherwise.
REQ-012 Sample positions are fixed: P=8 samples at 2,3,4; P=16 at 6,7,8; P=32 at 14,15,16.
REQ-013 While dat_samp_en=0, s0, s1 and sampled_bit SHALL hold their values and sample_valid SHALL be 0.
REQ-014 If enable=0 while dat_samp_en=1, no sample SHALL be taken beyond edge_cnt=0 matching; edge_cnt is held at 0, so a sample occurs only if H-2=0, which is impossible for legal P.
REQ-015 If enable falls mid-bit, any partial s0/s1 SHALL be retained but SHALL NOT produce sample_valid until a new edge_cnt=H is reached.
REQ-016 A prescale change while enable=1 SHALL NOT affect P, edge_cnt or sampling until enable returns to 0.
REQ-017 Majority SHALL be purely bitwise; no glitch filtering beyond the three-sample vote.

Reset
REQ-018 While rst=0, outputs SHALL be: edge_cnt=0, bit_cnt=0, sampled_bit=1 (idle level), sample_valid=0.
REQ-019 While rst=0, internal state SHALL be: s0=1, s1=1, P=8.
REQ-020 Reset SHALL take effect immediately and asynchronously, including mid-frame; the first update after release SHALL occur on the first rising clk edge with rst=1.

Verification
REQ-021 P=8, enable=1, dat_samp_en=1, rx_in=0 for 8 clocks -> sample_valid pulses once at edge_cnt=5, sampled_bit=0; at clock 8 edge_cnt=0 and bit_cnt=1.
REQ-022 P=16, rx_in=1,0,1 at edge_cnt=6,7,8 -> sampled_bit=1; rx_in=0,0,1 at the same positions -> sampled_bit=0.
REQ-023 enable held high for 16x8 clocks with P=8 -> bit_cnt counts 0..15 and then wraps to 0; exactly 16 sample_valid pulses.
REQ-024 P=32 captured, then prescale changed to 8 mid-frame -> sampling stays at edges 14,15,16; after enable=0 for 1 clock and then enable=1 -> sampling at edges 2,3,4.
REQ-025 prescale=12 -> behaves as P=8.
REQ-026 rst asserted at edge_cnt=3, bit_cnt=4 -> all outputs take their reset values immediately with no sample_valid; after release with enable=1 -> edge_cnt counts from 0.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
//   Oversampling position counter and three-sample majority voter for a UART
//   receiver. Tracks the oversample position inside the current bit and the
//   bit index inside the frame, and votes on three consecutive samples taken
//   around the middle of each bit.
//
// Ports
//   clk          in   receive oversampling clock, rising edge
//   rst          in   asynchronous active-low reset
//   rx_in        in   serial line, already synchronous to clk, idle high
//   prescale     in   oversampling ratio (8, 16 or 32; anything else -> 8)
//   enable       in   frame in progress, runs the counters
//   dat_samp_en  in   sampling enable
//   edge_cnt     out  oversample position within the current bit
//   bit_cnt      out  bit index within the frame (wraps modulo 16)
//   sampled_bit  out  majority-voted bit value
//   sample_valid out  one-cycle pulse, sampled_bit newly updated
// -----------------------------------------------------------------------------
module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       enable,
  input  logic       dat_samp_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_valid
);

  localparam int unsigned EdgeW = 6;
  localparam int unsigned BitW  = 4;

  localparam logic [EdgeW-1:0] PrescDefault = EdgeW'(8);
  localparam logic [EdgeW-1:0] Presc16      = EdgeW'(16);
  localparam logic [EdgeW-1:0] Presc32      = EdgeW'(32);

  // Registered state
  logic [EdgeW-1:0] p_q,        p_d;
  logic [EdgeW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BitW-1:0]  bit_cnt_q,  bit_cnt_d;
  logic             s0_q,       s0_d;
  logic             s1_q,       s1_d;
  logic             smp_q,      smp_d;
  logic             valid_q,    valid_d;

  // Derived positions
  logic [EdgeW-1:0] p_legal;
  logic [EdgeW-1:0] half;
  logic [EdgeW-1:0] pos_s0;
  logic [EdgeW-1:0] pos_s1;
  logic [EdgeW-1:0] pos_last;
  logic             vote;

  // Illegal ratios fall back to 8 so the sample positions stay meaningful
  always_comb begin
    p_legal = PrescDefault;
    case (prescale)
      PrescDefault: p_legal = PrescDefault;
      Presc16:      p_legal = Presc16;
      Presc32:      p_legal = Presc32;
      default:      p_legal = PrescDefault;
    endcase
  end

  // Sample points sit at H-2, H-1 and H, centred on the middle of the bit
  always_comb begin
    half     = p_q >> 1;
    pos_s0   = half - EdgeW'(2);
    pos_s1   = half - EdgeW'(1);
    pos_last = p_q - EdgeW'(1);
  end

  // Bitwise 2-of-3 vote using the current line value as the third sample
  assign vote = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);

  // Prescale capture and position counters
  always_comb begin
    p_d        = p_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;

    if (!enable) begin
      p_d        = p_legal;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (edge_cnt_q == pos_last) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + BitW'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + EdgeW'(1);
    end
  end

  // Sample capture, vote and valid pulse; all hold while sampling is disabled
  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    smp_d   = smp_q;
    valid_d = 1'b0;

    if (dat_samp_en) begin
      if (edge_cnt_q == pos_s0) begin
        s0_d = rx_in;
      end
      if (edge_cnt_q == pos_s1) begin
        s1_d = rx_in;
      end
      if (edge_cnt_q == half) begin
        smp_d   = vote;
        valid_d = 1'b1;
      end
    end
  end

  // State registers; reset leaves the line voter at the idle (high) level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q        <= PrescDefault;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      smp_q      <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      p_q        <= p_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      smp_q      <= smp_d;
      valid_q    <= valid_d;
    end
  end

  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign sampled_bit  = smp_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
//   Self-checking bench for uart_rx_sampler. A position model tracks the
//   expected edge/bit counters; every sample point pushes the expected voted
//   bit onto a queue that a negedge monitor pops when sample_valid fires.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       enable;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  uart_rx_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .enable       (enable),
    .dat_samp_en  (dat_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int bit_val;
    int edge_pos;
  } exp_t;

  exp_t exp_q[$];

  int n_checks;
  int n_errors;
  int n_valid;

  // Bench-side position model
  int m_p;
  int m_edge;
  int m_bit;
  int ms0;
  int ms1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int legal_p(input int p);
    if (p == 8 || p == 16 || p == 32) return p;
    return 8;
  endfunction

  function automatic int maj3(input int a, input int b, input int c);
    return (a + b + c) >= 2 ? 1 : 0;
  endfunction

  // Scoreboard monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sampled_bit", int'(sampled_bit), e.bit_val);
        check_eq("valid_edge", int'(edge_cnt), e.edge_pos);
      end
    end
  end

  // One clock with rx driven; updates the model and checks the counters
  task automatic step(input int rx);
    int h;
    h = m_p / 2;
    rx_in = rx[0];
    if (dat_samp_en) begin
      if (m_edge == h - 2) ms0 = rx;
      if (m_edge == h - 1) ms1 = rx;
      if (m_edge == h) begin
        exp_t e;
        e.bit_val  = maj3(ms0, ms1, rx);
        e.edge_pos = h + 1;
        exp_q.push_back(e);
      end
    end
    if (!enable) begin
      m_p    = legal_p(int'(prescale));
      m_edge = 0;
      m_bit  = 0;
    end else if (m_edge == m_p - 1) begin
      m_edge = 0;
      m_bit  = (m_bit + 1) % 16;
    end else begin
      m_edge++;
    end
    @(posedge clk);
    #1;
    check_eq("edge_cnt", int'(edge_cnt), m_edge);
    check_eq("bit_cnt", int'(bit_cnt), m_bit);
  endtask

  // One full bit: chosen values at the three sample points, noise elsewhere
  task automatic drive_bit(input logic [2:0] s);
    int h;
    int n;
    h = m_p / 2;
    n = m_p;
    for (int i = 0; i < n; i++) begin
      if (m_edge == h - 2)      step(int'(s[0]));
      else if (m_edge == h - 1) step(int'(s[1]));
      else if (m_edge == h)     step(int'(s[2]));
      else                      step(int'($urandom_range(0, 1)));
    end
  endtask

  task automatic idle(input int ncyc, input int presc);
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    prescale    = 6'(presc);
    for (int i = 0; i < ncyc; i++) step(1);
  endtask

  initial begin
    int v0;
    n_checks    = 0;
    n_errors    = 0;
    n_valid     = 0;
    rst         = 1'b0;
    rx_in       = 1'b1;
    prescale    = 6'd8;
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    m_p = 8; m_edge = 0; m_bit = 0; ms0 = 1; ms1 = 1;

    // Reset values
    #22;
    check_eq("rst_edge_cnt", int'(edge_cnt), 0);
    check_eq("rst_bit_cnt", int'(bit_cnt), 0);
    check_eq("rst_sampled_bit", int'(sampled_bit), 1);
    check_eq("rst_sample_valid", int'(sample_valid), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // P=8, line low for a whole bit
    idle(2, 8);
    enable = 1'b1; dat_samp_en = 1'b1;
    v0 = n_valid;
    for (int i = 0; i < 8; i++) step(0);
    #5;
    check_eq("p8_one_pulse", n_valid - v0, 1);
    check_eq("p8_end_edge", int'(edge_cnt), 0);
    check_eq("p8_end_bit", int'(bit_cnt), 1);

    // P=16 vote patterns
    idle(2, 16);
    enable = 1'b1; dat_samp_en = 1'b1;
    drive_bit(3'b101);
    drive_bit(3'b100);
    drive_bit(3'b011);
    drive_bit(3'b001);

    // P=8 for 16 bits: bit counter wraps, one pulse per bit
    idle(2, 8);
    enable = 1'b1; dat_samp_en = 1'b1;
    v0 = n_valid;
    for (int b = 0; b < 16; b++) drive_bit(3'($urandom_range(0, 7)));
    #5;
    check_eq("wrap_pulses", n_valid - v0, 16);
    check_eq("wrap_bit_cnt", int'(bit_cnt), 0);

    // P=32 captured, prescale changed mid-frame has no effect
    idle(2, 32);
    enable = 1'b1; dat_samp_en = 1'b1;
    drive_bit(3'b110);
    prescale = 6'd8;
    drive_bit(3'b010);
    drive_bit(3'b111);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    drive_bit(3'b011);
    drive_bit(3'b000);

    // Illegal ratio behaves as 8
    idle(2, 12);
    enable = 1'b1; dat_samp_en = 1'b1;
    drive_bit(3'b101);
    drive_bit(3'b010);

    // Sampling disabled: no pulses, voted value held
    dat_samp_en = 1'b0;
    v0 = n_valid;
    for (int i = 0; i < 8; i++) step(int'($urandom_range(0, 1)));
    #5;
    check_eq("dis_no_pulse", n_valid - v0, 0);
    check_eq("dis_hold", int'(sampled_bit), 0);
    #5;

    // Asynchronous reset mid-frame at edge 3, bit 4
    idle(2, 8);
    enable = 1'b1; dat_samp_en = 1'b1;
    for (int b = 0; b < 4; b++) drive_bit(3'b000);
    step(0); step(0); step(0);
    check_eq("pre_rst_edge", int'(edge_cnt), 3);
    check_eq("pre_rst_bit", int'(bit_cnt), 4);
    #3;
    rst = 1'b0;
    #1;
    check_eq("arst_edge_cnt", int'(edge_cnt), 0);
    check_eq("arst_bit_cnt", int'(bit_cnt), 0);
    check_eq("arst_sampled_bit", int'(sampled_bit), 1);
    check_eq("arst_sample_valid", int'(sample_valid), 0);
    @(posedge clk);
    #1;
    check_eq("arst_hold_edge", int'(edge_cnt), 0);
    check_eq("arst_hold_valid", int'(sample_valid), 0);
    m_p = 8; m_edge = 0; m_bit = 0; ms0 = 1; ms1 = 1;
    #3;
    rst = 1'b1;
    drive_bit(3'b100);
    drive_bit(3'b110);

    idle(3, 8);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog in case the run stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
